elevator_request_tracker: RTL

- Sits between the floor call buttons and the elevator next-state controllers.
- Latches absolute hall and car calls per floor and tracks the car's current floor from arrival pulses.
- Presents the calls to the controllers as car-relative 3-bit vectors: bit0 = at current floor, bit1 = any floor above, bit2 = any floor below.
- Clears calls when the car serves them with the door open.

---
 rtl/elevator_request_tracker.sv | 132 +++++++++++++
 1 files changed

// File: rtl/elevator_request_tracker.sv
// Latches hall/car calls per floor, tracks the car floor from arrival pulses,
// and presents calls to the controllers relative to the car (at / above / below).
module elevator_request_tracker #(
    parameter int N_FLOORS    = 3,
    parameter int FLOOR_W     = 2,
    parameter int RESET_FLOOR = 0
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [N_FLOORS-1:0] hall_up_btn,
    input  logic [N_FLOORS-1:0] hall_down_btn,
    input  logic [N_FLOORS-1:0] car_btn,
    input  logic                arrive,
    input  logic                open_cur,
    input  logic [1:0]          dir_cur,
    output logic [2:0]          button_up,
    output logic [2:0]          button_down,
    output logic [2:0]          button_in,
    output logic [FLOOR_W-1:0]  floor_idx,
    output logic                pending_any,
    output logic                range_err
);

    localparam logic [FLOOR_W-1:0]  TOP_FLOOR = FLOOR_W'(N_FLOORS - 1);
    localparam logic [FLOOR_W-1:0]  RST_FLOOR = FLOOR_W'(RESET_FLOOR);
    // No hall-up call exists at the top floor and no hall-down call at floor 0.
    localparam logic [N_FLOORS-1:0] UP_MASK   = ~(N_FLOORS'(1) << (N_FLOORS - 1));
    localparam logic [N_FLOORS-1:0] DN_MASK   = ~N_FLOORS'(1);

    logic [N_FLOORS-1:0] up_q, up_d;
    logic [N_FLOORS-1:0] dn_q, dn_d;
    logic [N_FLOORS-1:0] car_q, car_d;
    logic [N_FLOORS-1:0] up_prev_q, dn_prev_q, car_prev_q;
    logic [FLOOR_W-1:0]  floor_q, floor_d;
    logic                range_err_q, range_err_d;

    logic                go_up, go_dn;
    logic [N_FLOORS-1:0] here;
    logic [N_FLOORS-1:0] clr_up, clr_dn, clr_car;
    logic [N_FLOORS-1:0] rise_up, rise_dn, rise_car;

    // Direction 11 decodes to neither, so it behaves exactly like stop.
    assign go_up = (dir_cur == 2'b01);
    assign go_dn = (dir_cur == 2'b10);

    always_comb begin
        here = '0;
        for (int i = 0; i < N_FLOORS; i++) begin
            here[i] = (floor_q == FLOOR_W'(i));
        end
    end

    assign clr_car = open_cur             ? here : '0;
    assign clr_up  = (open_cur && !go_dn) ? here : '0;
    assign clr_dn  = (open_cur && !go_up) ? here : '0;

    assign rise_up  = hall_up_btn   & ~up_prev_q  & UP_MASK;
    assign rise_dn  = hall_down_btn & ~dn_prev_q  & DN_MASK;
    assign rise_car = car_btn       & ~car_prev_q;

    // A fresh press wins over a same-edge service clear.
    assign up_d  = (up_q  & ~clr_up)  | rise_up;
    assign dn_d  = (dn_q  & ~clr_dn)  | rise_dn;
    assign car_d = (car_q & ~clr_car) | rise_car;

    always_comb begin
        floor_d     = floor_q;
        range_err_d = range_err_q;
        if (arrive) begin
            if (go_up) begin
                if (floor_q == TOP_FLOOR) begin
                    range_err_d = 1'b1;
                end else begin
                    floor_d = floor_q + FLOOR_W'(1);
                end
            end else if (go_dn) begin
                if (floor_q == '0) begin
                    range_err_d = 1'b1;
                end else begin
                    floor_d = floor_q - FLOOR_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            up_q        <= '0;
            dn_q        <= '0;
            car_q       <= '0;
            // All-ones history masks buttons held through reset.
            up_prev_q   <= '1;
            dn_prev_q   <= '1;
            car_prev_q  <= '1;
            floor_q     <= RST_FLOOR;
            range_err_q <= 1'b0;
        end else begin
            up_q        <= up_d;
            dn_q        <= dn_d;
            car_q       <= car_d;
            up_prev_q   <= hall_up_btn;
            dn_prev_q   <= hall_down_btn;
            car_prev_q  <= car_btn;
            floor_q     <= floor_d;
            range_err_q <= range_err_d;
        end
    end

    function automatic logic [2:0] rel_map(input logic [N_FLOORS-1:0] p,
                                           input logic [FLOOR_W-1:0]  f);
        logic [2:0] r;
        r = 3'b000;
        for (int i = 0; i < N_FLOORS; i++) begin
            if (f == FLOOR_W'(i)) begin
                r[0] = r[0] | p[i];
            end else if (f < FLOOR_W'(i)) begin
                r[1] = r[1] | p[i];
            end else begin
                r[2] = r[2] | p[i];
            end
        end
        return r;
    endfunction

    assign button_up   = rel_map(up_q, floor_q);
    assign button_down = rel_map(dn_q, floor_q);
    assign button_in   = rel_map(car_q, floor_q);
    assign floor_idx   = floor_q;
    assign pending_any = |{up_q, dn_q, car_q};
    assign range_err   = range_err_q;

endmodule
